ifetch: RTL and testbench

Instruction fetch stage, sitting directly upstream of the decoder. It holds the architectural fetch PC, requests 32-bit instruction words from the instruction cache at halfword-aligned addresses, and presents one instruction per handshake to the decoder together with a branch-direction prediction. It advances the PC from the decoder's `next_pc`, stalls on JALR (including C.JR/C.JALR) until the target resolves, and redirects on ROB flush. It owns a bimodal branch history table (2-bit saturating counters) updated by the ROB at branch commit.

---
 rtl/ifetch.sv | 142 ++++++++++++++
 tb/tb_ifetch.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// ifetch - instruction fetch stage ahead of the decoder.
//
// Holds the fetch PC and requests 32-bit words from the icache at
// halfword-aligned addresses. It presents one instruction at a time to the
// decoder along with a bimodal branch prediction. It stalls on JALR until the
// target is resolved, and it redirects on a ROB flush.
//
// Ports:
//   clk_in, rst_in           clock, asynchronous active-high reset
//   rdy_in                   global pause; low freezes all state (BHT too)
//   icache_req/addr          fetch request and address (held until valid)
//   icache_valid/inst        icache response
//   to_decoder, pc, inst     presented instruction and its PC
//   predict                  predicted-taken bit from the BHT
//   next_pc, dec_accept      decoder successor PC and consume strobe
//   jalr_done/target         resolved JALR target
//   rob_clear/rob_clear_pc   misprediction flush and restart PC
//   bht_update/pc/taken      branch commit training port
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | one dead cycle; request low so the icache aborts
// FETCH     | request outstanding at pc_reg
// ISSUE     | instruction held in inst_reg, offered to the decoder
// WAIT_JALR | JALR consumed, waiting for its target
module ifetch #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          BHT_ADDR_BIT = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_inst,
  output logic        to_decoder,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        predict,
  input  logic [31:0] next_pc,
  input  logic        dec_accept,
  input  logic        jalr_done,
  input  logic [31:0] jalr_target,
  input  logic        rob_clear,
  input  logic [31:0] rob_clear_pc,
  input  logic        bht_update,
  input  logic [31:0] bht_pc,
  input  logic        bht_taken
);

  localparam int BHT_SIZE = 1 << BHT_ADDR_BIT;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT_JALR} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_reg, pc_nxt;
  logic [31:0] inst_reg, inst_nxt;
  logic [1:0]  bht [BHT_SIZE];

  logic [BHT_ADDR_BIT-1:0] rd_idx, wr_idx;
  logic                    is_jalr;

  assign rd_idx = pc_reg[BHT_ADDR_BIT:1];
  assign wr_idx = bht_pc[BHT_ADDR_BIT:1];

  // JALR, or compressed C.JR/C.JALR (bit 12 distinguishes those two; both stall).
  assign is_jalr = (inst_reg[1:0] == 2'b11 && inst_reg[6:0] == 7'b1100111) ||
                   (inst_reg[1:0] == 2'b10 && inst_reg[15:13] == 3'b100 &&
                    inst_reg[6:2] == 5'd0 && inst_reg[11:7] != 5'd0);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_reg;
    inst_nxt  = inst_reg;
    if (rob_clear) begin
      pc_nxt    = rob_clear_pc;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  state_nxt = FETCH;
        FETCH: begin
          if (icache_valid) begin
            inst_nxt  = icache_inst;
            state_nxt = ISSUE;
          end
        end
        ISSUE: begin
          if (dec_accept) begin
            if (is_jalr) begin
              state_nxt = WAIT_JALR;
            end else begin
              pc_nxt    = next_pc;
              state_nxt = FETCH;
            end
          end
        end
        WAIT_JALR: begin
          if (jalr_done) begin
            pc_nxt    = jalr_target;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      pc_reg   <= RESET_PC;
      inst_reg <= 32'h0;
    end else if (rdy_in) begin
      state    <= state_nxt;
      pc_reg   <= pc_nxt;
      inst_reg <= inst_nxt;
    end
  end

  // Reads use the registered array, so a same-cycle update to the predicted
  // index only becomes visible on the following cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
    end else if (rdy_in && bht_update) begin
      if (bht_taken) begin
        if (bht[wr_idx] != 2'b11) bht[wr_idx] <= bht[wr_idx] + 2'b01;
      end else begin
        if (bht[wr_idx] != 2'b00) bht[wr_idx] <= bht[wr_idx] - 2'b01;
      end
    end
  end

  assign icache_req  = (state == FETCH);
  assign icache_addr = pc_reg;
  assign to_decoder  = (state == ISSUE) && !rob_clear;
  assign pc          = pc_reg;
  assign inst        = inst_reg;
  assign predict     = (state == ISSUE) && bht[rd_idx][1];

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

  logic        clk_in, rst_in, rdy_in;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic [31:0] icache_inst;
  logic        to_decoder;
  logic [31:0] pc, inst;
  logic        predict;
  logic [31:0] next_pc;
  logic        dec_accept, jalr_done;
  logic [31:0] jalr_target;
  logic        rob_clear;
  logic [31:0] rob_clear_pc;
  logic        bht_update;
  logic [31:0] bht_pc;
  logic        bht_taken;

  int checks   = 0;
  int failures = 0;

  ifetch #(.RESET_PC(32'h0), .BHT_ADDR_BIT(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_valid(icache_valid), .icache_inst(icache_inst),
    .to_decoder(to_decoder), .pc(pc), .inst(inst), .predict(predict),
    .next_pc(next_pc), .dec_accept(dec_accept),
    .jalr_done(jalr_done), .jalr_target(jalr_target),
    .rob_clear(rob_clear), .rob_clear_pc(rob_clear_pc),
    .bht_update(bht_update), .bht_pc(bht_pc), .bht_taken(bht_taken)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    rdy_in = 1'b1; icache_valid = 1'b0; icache_inst = 32'h0;
    next_pc = 32'h0; dec_accept = 1'b0; jalr_done = 1'b0; jalr_target = 32'h0;
    rob_clear = 1'b0; rob_clear_pc = 32'h0;
    bht_update = 1'b0; bht_pc = 32'h0; bht_taken = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    #2;
    rst_in = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    tick();
    do_reset();
    checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", icache_req); end
    checks++; if (icache_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", icache_addr); end
    checks++; if (to_decoder !== 1'b0) begin failures++; $display("FAIL reset_to_dec got=%0h exp=0", to_decoder); end
    checks++; if (pc !== 32'h0 || inst !== 32'h0) begin failures++; $display("FAIL reset_pc_inst got=%0h/%0h exp=0/0", pc, inst); end
    checks++; if (predict !== 1'b0) begin failures++; $display("FAIL reset_predict got=%0h exp=0", predict); end
    tick();
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h0 || to_decoder !== 1'b0) begin
      failures++; $display("FAIL reset_first_fetch got req=%0h addr=%0h td=%0h exp 1/0/0", icache_req, icache_addr, to_decoder); end
  endtask

  task automatic test_sequential();
    icache_valid = 1'b1; icache_inst = 32'h00100093;
    tick();
    icache_valid = 1'b0;
    checks++; if (to_decoder !== 1'b1 || inst !== 32'h00100093 || pc !== 32'h0) begin
      failures++; $display("FAIL seq_issue got td=%0h inst=%0h pc=%0h exp 1/00100093/0", to_decoder, inst, pc); end
    checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL seq_req_in_issue got=%0h exp=0", icache_req); end
    dec_accept = 1'b1; next_pc = 32'h4;
    tick();
    dec_accept = 1'b0;
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h4 || to_decoder !== 1'b0) begin
      failures++; $display("FAIL seq_next_fetch got req=%0h addr=%0h td=%0h exp 1/4/0", icache_req, icache_addr, to_decoder); end
  endtask

  task automatic test_backpressure();
    icache_valid = 1'b1; icache_inst = 32'h00000013;
    tick();
    icache_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (to_decoder !== 1'b1 || pc !== 32'h4 || inst !== 32'h00000013) begin
        failures++; $display("FAIL bp_hold_%0d got td=%0h pc=%0h inst=%0h exp 1/4/13", i, to_decoder, pc, inst); end
    end
    dec_accept = 1'b1; next_pc = 32'h10;
    tick();
    dec_accept = 1'b0;
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h10) begin
      failures++; $display("FAIL bp_fetch got req=%0h addr=%0h exp 1/10", icache_req, icache_addr); end
  endtask

  task automatic test_jalr();
    logic [31:0] words [2];
    logic [31:0] targets [2];
    words[0] = 32'h000080e7; words[1] = 32'hABCD8082;
    targets[0] = 32'h1000; targets[1] = 32'h2002;
    for (int k = 0; k < 2; k++) begin
      icache_valid = 1'b1; icache_inst = words[k];
      tick();
      icache_valid = 1'b0;
      dec_accept = 1'b1; next_pc = icache_addr + 32'h4;
      tick();
      dec_accept = 1'b0;
      for (int i = 0; i < 3; i++) begin
        checks++; if (icache_req !== 1'b0 || to_decoder !== 1'b0) begin
          failures++; $display("FAIL jalr%0d_stall_%0d got req=%0h td=%0h exp 0/0", k, i, icache_req, to_decoder); end
        tick();
      end
      jalr_done = 1'b1; jalr_target = targets[k];
      tick();
      jalr_done = 1'b0;
      checks++; if (icache_req !== 1'b1 || icache_addr !== targets[k]) begin
        failures++; $display("FAIL jalr%0d_target got req=%0h addr=%0h exp 1/%0h", k, icache_req, icache_addr, targets[k]); end
    end
  endtask

  task automatic test_flush();
    icache_valid = 1'b1; icache_inst = 32'h00000013;
    rob_clear = 1'b1; rob_clear_pc = 32'h200;
    tick();
    icache_valid = 1'b0; rob_clear = 1'b0;
    checks++; if (icache_req !== 1'b0 || to_decoder !== 1'b0) begin
      failures++; $display("FAIL flush_idle got req=%0h td=%0h exp 0/0", icache_req, to_decoder); end
    tick();
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h200 || to_decoder !== 1'b0) begin
      failures++; $display("FAIL flush_refetch got req=%0h addr=%0h td=%0h exp 1/200/0", icache_req, icache_addr, to_decoder); end
    // clear while presenting, with a simultaneous accept
    icache_valid = 1'b1; icache_inst = 32'h00000013;
    tick();
    icache_valid = 1'b0;
    rob_clear = 1'b1; rob_clear_pc = 32'h40; dec_accept = 1'b1; next_pc = 32'h204;
    #1;
    checks++; if (to_decoder !== 1'b0) begin failures++; $display("FAIL flush_force_td got=%0h exp=0", to_decoder); end
    tick();
    rob_clear = 1'b0; dec_accept = 1'b0;
    tick();
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h40) begin
      failures++; $display("FAIL flush_accept_void got req=%0h addr=%0h exp 1/40", icache_req, icache_addr); end
  endtask

  task automatic test_bht();
    logic exp_pred [6];
    exp_pred[0] = 1'b1; exp_pred[1] = 1'b1; exp_pred[2] = 1'b1; exp_pred[3] = 1'b1;
    exp_pred[4] = 1'b1; exp_pred[5] = 1'b0;
    icache_valid = 1'b1; icache_inst = 32'h00000063;
    tick();
    icache_valid = 1'b0;
    checks++; if (predict !== 1'b0 || pc !== 32'h40) begin
      failures++; $display("FAIL bht_initial got pred=%0h pc=%0h exp 0/40", predict, pc); end
    bht_pc = 32'h40;
    for (int i = 0; i < 6; i++) begin
      bht_update = 1'b1; bht_taken = (i < 4);
      tick();
      bht_update = 1'b0;
      checks++; if (predict !== exp_pred[i]) begin
        failures++; $display("FAIL bht_step_%0d got=%0h exp=%0h", i, predict, exp_pred[i]); end
    end
    // same-cycle collision: predict shows the value before the update
    bht_update = 1'b1; bht_taken = 1'b1;
    #1;
    checks++; if (predict !== 1'b0) begin failures++; $display("FAIL bht_collision got=%0h exp=0", predict); end
    tick();
    bht_update = 1'b1; bht_taken = 1'b0;
    tick();
    bht_update = 1'b0;
    checks++; if (predict !== 1'b0) begin failures++; $display("FAIL bht_back_to_01 got=%0h exp=0", predict); end
  endtask

  task automatic test_rdy();
    rdy_in = 1'b0; dec_accept = 1'b1; next_pc = 32'h80;
    bht_update = 1'b1; bht_pc = 32'h40; bht_taken = 1'b1;
    tick(); tick();
    checks++; if (to_decoder !== 1'b1 || pc !== 32'h40 || predict !== 1'b0 || icache_req !== 1'b0) begin
      failures++; $display("FAIL rdy_freeze got td=%0h pc=%0h pred=%0h req=%0h exp 1/40/0/0", to_decoder, pc, predict, icache_req); end
    rdy_in = 1'b1; bht_update = 1'b0;
    tick();
    dec_accept = 1'b0;
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h80) begin
      failures++; $display("FAIL rdy_resume got req=%0h addr=%0h exp 1/80", icache_req, icache_addr); end
  endtask

  // Reference model: the fetch unit viewed as "what is it doing right now".
  localparam int M_DEAD = 0, M_ASK = 1, M_OFFER = 2, M_STALL = 3;

  function automatic bit ref_is_jalr(input logic [31:0] w);
    int rs1;
    rs1 = (w >> 7) & 31;
    if ((w & 32'h7f) == 32'h67) return 1'b1;
    if ((w & 32'he07f) == 32'h8002 && rs1 != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return (r & 32'hffffff80) | 32'h67;
      1: return (r & 32'hffff0000) | 32'h8002 | ((r & 32'h1f) << 7);
      2: return (r & 32'hffff0000) | 32'h9002 | ((r & 32'h1f) << 7);
      default: return r;
    endcase
  endfunction

  task automatic test_random();
    int          m_mode;
    logic [31:0] m_pc, m_inst;
    int          m_bht [64];
    bit          e_req, e_td, e_pred;
    int          ridx, widx;
    clear_inputs();
    do_reset();
    m_mode = M_DEAD; m_pc = 32'h0; m_inst = 32'h0;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy_in       = ($urandom_range(0, 9) != 0);
      icache_valid = $urandom_range(0, 1);
      icache_inst  = rand_word();
      dec_accept   = $urandom_range(0, 1);
      next_pc      = {$urandom} & 32'hfffffffe;
      jalr_done    = ($urandom_range(0, 2) == 0);
      jalr_target  = {$urandom} & 32'hfffffffe;
      rob_clear    = ($urandom_range(0, 19) == 0);
      rob_clear_pc = {$urandom} & 32'hfffffffe;
      bht_update   = $urandom_range(0, 1);
      bht_pc       = $urandom_range(0, 1) ? m_pc : ({$urandom} & 32'hfffffffe);
      bht_taken    = $urandom_range(0, 1);
      #1;
      ridx   = int'((m_pc >> 1) % 64);
      e_req  = (m_mode == M_ASK);
      e_td   = (m_mode == M_OFFER) && !rob_clear;
      e_pred = (m_mode == M_OFFER) && (m_bht[ridx] >= 2);
      checks++; if (icache_req !== e_req) begin failures++; $display("FAIL rnd_req cyc=%0d got=%0h exp=%0h", cyc, icache_req, e_req); end
      checks++; if (icache_addr !== m_pc || pc !== m_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%0h/%0h exp=%0h", cyc, icache_addr, pc, m_pc); end
      checks++; if (to_decoder !== e_td) begin failures++; $display("FAIL rnd_to_dec cyc=%0d got=%0h exp=%0h", cyc, to_decoder, e_td); end
      checks++; if (inst !== m_inst) begin failures++; $display("FAIL rnd_inst cyc=%0d got=%0h exp=%0h", cyc, inst, m_inst); end
      checks++; if (predict !== e_pred) begin failures++; $display("FAIL rnd_predict cyc=%0d got=%0h exp=%0h", cyc, predict, e_pred); end
      @(posedge clk_in);
      if (rdy_in) begin
        if (bht_update) begin
          widx = int'((bht_pc >> 1) % 64);
          if (bht_taken) m_bht[widx] = (m_bht[widx] == 3) ? 3 : m_bht[widx] + 1;
          else           m_bht[widx] = (m_bht[widx] == 0) ? 0 : m_bht[widx] - 1;
        end
        if (rob_clear) begin
          m_pc = rob_clear_pc; m_mode = M_DEAD;
        end else if (m_mode == M_DEAD) begin
          m_mode = M_ASK;
        end else if (m_mode == M_ASK && icache_valid) begin
          m_inst = icache_inst; m_mode = M_OFFER;
        end else if (m_mode == M_OFFER && dec_accept) begin
          if (ref_is_jalr(m_inst)) m_mode = M_STALL;
          else begin m_pc = next_pc; m_mode = M_ASK; end
        end else if (m_mode == M_STALL && jalr_done) begin
          m_pc = jalr_target; m_mode = M_ASK;
        end
      end
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    rst_in = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_backpressure();
    test_jalr();
    test_flush();
    test_bht();
    test_rdy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
